// File: rtl/e_alu_wb_queue_pkg.sv
// Shared definitions for the ALU writeback result queue: default field widths
// and the default-width entry layout used across the execute/writeback boundary.
package e_alu_wb_queue_pkg;

    localparam int RESULT_W   = 32;
    localparam int ROB_W_DEF  = 6;
    localparam int PREG_W_DEF = 6;

    typedef struct packed {
        logic [RESULT_W-1:0]   result;
        logic [ROB_W_DEF-1:0]  rob_id;
        logic [PREG_W_DEF-1:0] preg;
        logic                  wen;
    } alu_wb_entry_t;

    // Occupancy counter width; one extra bit so DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/e_wb_fifo_ctrl.sv
// Head/tail/count bookkeeping for the writeback queue. Full/empty come from the
// occupancy counter; flush zeroes all pointers on the next edge.
module e_wb_fifo_ctrl
    import e_alu_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_req_i,
    input  logic             pop_req_i,
    output logic             push_o,
    output logic             pop_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);

    // Flush suppresses both sides so a racing pop never retires an entry.
    assign push_o = push_req_i && !full_o  && !flush_i;
    assign pop_o  = pop_req_i  && !empty_o && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_o) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_o)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_o, pop_o})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign wr_ptr_o = wr_ptr;
    assign rd_ptr_o = rd_ptr;
    assign count_o  = count;

endmodule

// File: rtl/e_alu_wb_queue.sv
// In-order result buffer between the ALU execute stage and the CDB arbiter.
// Optional same-cycle forwarding into an empty queue: define E_ALU_WB_BYPASS_EN.
module e_alu_wb_queue
    import e_alu_wb_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ROB_W  = ROB_W_DEF,
    parameter int PREG_W = PREG_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [RESULT_W-1:0]       in_result_i,
    input  logic [ROB_W-1:0]          in_rob_id_i,
    input  logic [PREG_W-1:0]         in_preg_i,
    input  logic                      in_wen_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [RESULT_W-1:0]       out_result_o,
    output logic [ROB_W-1:0]          out_rob_id_o,
    output logic [PREG_W-1:0]         out_preg_o,
    output logic                      out_wen_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [RESULT_W-1:0] result;
        logic [ROB_W-1:0]    rob_id;
        logic [PREG_W-1:0]   preg;
        logic                wen;
    } entry_t;

    entry_t           in_e;
    entry_t           head_e;
    entry_t           sel_e;
    entry_t           out_e;
    entry_t           mem [DEPTH];
    logic             push;
    logic             pop;
    logic             bypass;
    logic             full;
    logic             empty;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign in_e = '{result: in_result_i, rob_id: in_rob_id_i,
                    preg: in_preg_i, wen: in_wen_i};

`ifdef E_ALU_WB_BYPASS_EN
    // Empty queue and an immediate grant: hand the result straight to the CDB.
    assign bypass = empty && in_valid_i && out_ready_i && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    e_wb_fifo_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .push_req_i (in_valid_i && !bypass),
        .pop_req_i  (out_ready_i),
        .push_o     (push),
        .pop_o      (pop),
        .wr_ptr_o   (wr_ptr),
        .rd_ptr_o   (rd_ptr),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty)
    );

    // Payload storage has no reset; validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_e;
    end

    assign head_e      = mem[rd_ptr];
    assign sel_e       = bypass ? in_e : head_e;
    assign out_valid_o = !flush_i && (!empty || bypass);
    assign out_e       = out_valid_o ? sel_e : '0;

    assign out_result_o = out_e.result;
    assign out_rob_id_o = out_e.rob_id;
    assign out_preg_o   = out_e.preg;
    assign out_wen_o    = out_e.wen;
    assign in_ready_o   = !full;
    assign count_o      = count;

endmodule

// File: tb/tb_e_alu_wb_queue.sv
// Scoreboard bench for e_alu_wb_queue: directed scenarios plus random traffic,
// expected entries tracked in a behavioural queue model.
module tb_e_alu_wb_queue;

    localparam int DEPTH  = 4;
    localparam int ROB_W  = 6;
    localparam int PREG_W = 6;
`ifdef E_ALU_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0]       result;
        logic [ROB_W-1:0]  rob_id;
        logic [PREG_W-1:0] preg;
        logic              wen;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_result = '0;
    logic [ROB_W-1:0]  in_rob = '0;
    logic [PREG_W-1:0] in_preg = '0;
    logic              in_wen = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_result;
    logic [ROB_W-1:0]  out_rob;
    logic [PREG_W-1:0] out_preg;
    logic              out_wen;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    ent_t exp_q[$];
    bit   pend_v = 1'b0;
    bit   pend_fl = 1'b0;
    ent_t pend_e;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    e_alu_wb_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .PREG_W(PREG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_result_i  (in_result),
        .in_rob_id_i  (in_rob),
        .in_preg_i    (in_preg),
        .in_wen_i     (in_wen),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_result_o (out_result),
        .out_rob_id_o (out_rob),
        .out_preg_o   (out_preg),
        .out_wen_o    (out_wen),
        .count_o      (count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Model: a forwarded result exists only when nothing is queued and the grant is present.
    function automatic bit model_bypass();
        return BYP && exp_q.size() == 0 && in_valid && out_ready && !flush;
    endfunction

    // Monitor: compare DUT outputs against the model every cycle, pop on a completed handshake.
    ent_t mon_exp;
    ent_t mon_act;
    bit   mon_byp;
    bit   mon_vld;
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            mon_byp = model_bypass();
            mon_vld = !flush && (exp_q.size() != 0 || mon_byp);
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
            chk("out_valid", 64'(out_valid), 64'(mon_vld));
            if (!mon_vld)     mon_exp = '0;
            else if (mon_byp) mon_exp = '{in_result, in_rob, in_preg, in_wen};
            else              mon_exp = exp_q[0];
            mon_act = '{out_result, out_rob, out_preg, out_wen};
            chk("out_fields", 64'(mon_act), 64'(mon_exp));
            if (mon_vld && out_ready && !mon_byp) void'(exp_q.pop_front());
        end
    end

    // One cycle of stimulus: retire last cycle's model effects, then drive new inputs.
    task automatic step(input bit v, input logic [31:0] res, input logic [ROB_W-1:0] rob,
                        input logic [PREG_W-1:0] preg, input bit wen, input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        if (pend_fl)     exp_q.delete();
        else if (pend_v) exp_q.push_back(pend_e);
        in_valid  = v;
        in_result = res;
        in_rob    = rob;
        in_preg   = preg;
        in_wen    = wen;
        out_ready = ordy;
        flush     = fl;
        pend_fl   = fl;
        pend_v    = v && !fl && exp_q.size() < DEPTH && !model_bypass();
        pend_e    = '{res, rob, preg, wen};
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 32'h0, '0, '0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_result", 64'(out_result), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single push held at the output
        step(1'b1, 32'h1234_5678, 6'd5, 6'd9, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Fill, attempt a fifth push, then drain in order
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 6'(i), 6'(i + 8), 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'd5, 6'd5, 6'd13, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b1);

        // Continuous push/pop stream wrapping the pointers
        for (int i = 0; i < 10; i++) step(1'b1, 32'(i), 6'(i), 6'(i), i[0], 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Flush racing a push and a pop
        step(1'b1, 32'd100, 6'd1, 6'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'd101, 6'd2, 6'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'd7,   6'd3, 6'd3, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Push into empty queue with immediate grant
        step(1'b1, 32'hDEAD, 6'd4, 6'd4, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) step(1'b1, 32'(200 + i), 6'(i), 6'(i), 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pend_v   = 1'b0;
        pend_fl  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom, 6'($urandom_range(0, 63)),
                 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 6; i++) idle(1'b1);
        @(posedge clk);
        #1;
        chk("drained", 64'(exp_q.size() + (pend_v ? 1 : 0)), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
